// File: rtl/replica_timing_monitor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : replica_timing_monitor_ctrl
// Purpose  : Drives the replica ALU inverter chain as a timing-margin canary.
//            A probe toggles the replica input, then captures the replica
//            output one clock later. A mismatch means the replica path, and
//            so the ALU critical path, missed timing. Each failed probe raises
//            an error pulse and a stall request. Errors are counted over
//            windows of probes, and a hysteretic performance-level request
//            is derived from those counts.
// Revision : 1.0 - initial release
// ============================================================================
module replica_timing_monitor_ctrl #(
  parameter int PROBE_INTERVAL = 16,
  parameter int WINDOW_PROBES  = 8,
  parameter int ERR_HI_THRESH  = 2,
  parameter int CALM_WINDOWS   = 4,
  parameter int LEVEL_MAX      = 3,
  parameter int LEVEL_W        = 2,
  parameter int STALL_CYCLES   = 4,
  parameter bit REPLICA_INVERT = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  output logic               replica_launch_o,
  input  logic               replica_capture_i,
  output logic               timing_err_o,
  output logic               stall_req_o,
  output logic [LEVEL_W-1:0] perf_level_o,
  output logic               level_change_o,
  output logic [15:0]        err_total_o,
  output logic               busy_o
);

  localparam int WAIT_W  = (PROBE_INTERVAL > 4) ? $clog2(PROBE_INTERVAL) : 1;
  localparam int PROBE_W = $clog2(WINDOW_PROBES + 1);
  localparam int CALM_W  = $clog2(CALM_WINDOWS + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  // The WAIT state lasts PROBE_INTERVAL-3 cycles. Together with LAUNCH,
  // SAMPLE and EVAL, that gives a launch-to-launch period of PROBE_INTERVAL.
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(PROBE_INTERVAL - 4);
  localparam logic [PROBE_W-1:0] WIN_LAST   = PROBE_W'(WINDOW_PROBES - 1);
  localparam logic [PROBE_W-1:0] WIN_FULL   = PROBE_W'(WINDOW_PROBES);
  localparam logic [PROBE_W-1:0] ERR_HI     = PROBE_W'(ERR_HI_THRESH);
  localparam logic [CALM_W-1:0]  CALM_LAST  = CALM_W'(CALM_WINDOWS - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP    = LEVEL_W'(LEVEL_MAX);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SAMPLE = 3'd2,
    S_EVAL   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t              state;
  logic                launch_q;
  logic                sample_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STALL_W-1:0]  stall_cnt;
  logic [PROBE_W-1:0]  probe_cnt;
  logic [PROBE_W-1:0]  win_err;
  logic [CALM_W-1:0]   calm_cnt;

  logic                eval_fire;
  logic                mismatch;
  logic                win_done;
  logic [PROBE_W-1:0]  win_errs_next;

  // A probe is only evaluated if the monitor is still enabled in EVAL.
  // Dropping en_i discards the probe that is in flight.
  assign eval_fire     = (state == S_EVAL) && en_i;
  assign mismatch      = (sample_q != (launch_q ^ REPLICA_INVERT));
  assign win_done      = (probe_cnt == WIN_LAST);
  assign win_errs_next = (mismatch && (win_err != WIN_FULL)) ? win_err + 1'b1 : win_err;

  assign replica_launch_o = launch_q;
  assign stall_req_o      = (stall_cnt != '0);
  assign busy_o           = (state != S_IDLE);

  // Probe sequencer: launch toggle, one-cycle capture, evaluate, then pad out the interval.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      launch_q <= 1'b0;
      sample_q <= 1'b0;
      wait_cnt <= '0;
    end else if (!en_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state <= S_LAUNCH;
        S_LAUNCH: begin
          launch_q <= ~launch_q;
          state    <= S_SAMPLE;
        end
        S_SAMPLE: begin
          sample_q <= replica_capture_i;
          state    <= S_EVAL;
        end
        S_EVAL: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_LAUNCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Error reporting, stall timer, statistics and the windowed hysteretic level request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timing_err_o   <= 1'b0;
      level_change_o <= 1'b0;
      perf_level_o   <= '0;
      err_total_o    <= '0;
      stall_cnt      <= '0;
      probe_cnt      <= '0;
      win_err        <= '0;
      calm_cnt       <= '0;
    end else begin
      timing_err_o   <= eval_fire && mismatch;
      level_change_o <= 1'b0;

      // A new error restarts the stall window, even if a stall is already in progress.
      if (eval_fire && mismatch) begin
        stall_cnt <= STALL_LOAD;
      end else if (stall_cnt != '0) begin
        stall_cnt <= stall_cnt - 1'b1;
      end

      // Clearing takes precedence over the probe's statistics. A window that
      // would complete on the same cycle is discarded, so the level holds.
      if (clr_i) begin
        err_total_o <= '0;
        probe_cnt   <= '0;
        win_err     <= '0;
        calm_cnt    <= '0;
      end else if (eval_fire) begin
        if (mismatch && (err_total_o != 16'hFFFF)) begin
          err_total_o <= err_total_o + 16'd1;
        end
        if (win_done) begin
          probe_cnt <= '0;
          win_err   <= '0;
          if (win_errs_next >= ERR_HI) begin
            calm_cnt <= '0;
            if (perf_level_o != LVL_TOP) begin
              perf_level_o   <= perf_level_o + 1'b1;
              level_change_o <= 1'b1;
            end
          end else if (win_errs_next == '0) begin
            if (calm_cnt == CALM_LAST) begin
              calm_cnt <= '0;
              if (perf_level_o != '0) begin
                perf_level_o   <= perf_level_o - 1'b1;
                level_change_o <= 1'b1;
              end
            end else begin
              calm_cnt <= calm_cnt + 1'b1;
            end
          end else begin
            calm_cnt <= '0;
          end
        end else begin
          probe_cnt <= probe_cnt + 1'b1;
          win_err   <= win_errs_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_replica_timing_monitor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_replica_timing_monitor_ctrl
// Purpose  : Scoreboard bench for replica_timing_monitor_ctrl. For each probe,
//            the stimulus pushes the expected response. A monitor detects
//            each completed probe from the DUT outputs and checks the DUT
//            against that expected response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_replica_timing_monitor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, clr, en4;
  int          mode;  // 0 loopback, 1 capture tied low, 2 inverted (forced mismatch)
  logic        launch, capture, terr, stall, chg, busy;
  logic [1:0]  lvl;
  logic [15:0] total;
  logic        launch4, terr4, stall4, chg4, busy4;
  logic [1:0]  lvl4;
  logic [15:0] total4;

  assign capture = (mode == 0) ? launch : ((mode == 1) ? 1'b0 : ~launch);

  replica_timing_monitor_ctrl dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .replica_launch_o(launch), .replica_capture_i(capture),
    .timing_err_o(terr), .stall_req_o(stall), .perf_level_o(lvl),
    .level_change_o(chg), .err_total_o(total), .busy_o(busy)
  );

  // Fast-probe instance whose replica always misses timing.
  replica_timing_monitor_ctrl #(.PROBE_INTERVAL(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en4), .clr_i(1'b0),
    .replica_launch_o(launch4), .replica_capture_i(~launch4),
    .timing_err_o(terr4), .stall_req_o(stall4), .perf_level_o(lvl4),
    .level_change_o(chg4), .err_total_o(total4), .busy_o(busy4)
  );

  typedef struct packed {
    logic        terr;
    logic        chg;
    logic        stall;
    logic [1:0]  lvl;
    logic [15:0] total;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   tog = 0;
  int   prev_tog = 0;
  int   exp_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a launch toggle while busy, still busy one cycle later, means a probe result appears two cycles after the toggle.
  initial begin : monitor
    logic prev;
    exp_t a, e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((launch !== prev) && (busy === 1'b1)) begin
        prev_tog = tog;
        tog      = cyc;
        @(negedge clk);
        if (busy === 1'b1) begin
          @(negedge clk);
          a = {terr, chg, stall, lvl, total};
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL probe_unexpected actual terr=%0b chg=%0b stall=%0b lvl=%0d total=%0d required no probe",
                     a.terr, a.chg, a.stall, a.lvl, a.total);
          end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
              failures++;
              $display("FAIL probe_result actual terr=%0b chg=%0b stall=%0b lvl=%0d total=%0d required terr=%0b chg=%0b stall=%0b lvl=%0d total=%0d",
                       a.terr, a.chg, a.stall, a.lvl, a.total, e.terr, e.chg, e.stall, e.lvl, e.total);
            end
          end
          done_cnt++;
        end
      end
      prev = launch;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) return;
    end
    checks++;
    failures++;
    $display("FAIL probe_timeout actual=no_result required=result_%0d", target);
    exp_q.delete();
  endtask

  // Stall equals the error flag at the result cycle when probes are 16 cycles apart.
  task automatic expect_probe(input int m, input logic t, input logic c,
                              input logic [1:0] l, input logic [15:0] tot);
    int target;
    mode = m;
    exp_q.push_back({t, c, t, l, tot});
    target = done_cnt + 1;
    wait_done(target);
  endtask

  task automatic wait_toggle(input string name);
    logic p;
    p = launch;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (launch !== p) return;
    end
    checks++;
    failures++;
    $display("FAIL %s actual=no_toggle required=toggle", name);
  endtask

  // Capture tied low from an even launch count: even probes fail, odd probes pass.
  task automatic run_tied0(input int n);
    int w;
    logic last;
    logic [1:0] l;
    for (int k = 0; k < n; k++) begin
      w    = k / 8;
      last = ((k % 8) == 7);
      if (last) l = (w + 1 > 3) ? 2'd3 : 2'(w + 1);
      else      l = (w > 3) ? 2'd3 : 2'(w);
      if ((k % 2) == 0) exp_total++;
      expect_probe(1, ((k % 2) == 0), (last && (w < 3)), l, 16'(exp_total));
    end
  endtask

  // One window of loopback probes, optionally with a forced mismatch on its first probe.
  task automatic run_window(input logic err_first, input logic [1:0] lb, input logic [1:0] la);
    int m;
    for (int i = 0; i < 8; i++) begin
      m = (err_first && (i == 0)) ? 2 : 0;
      if (m == 2) exp_total++;
      expect_probe(m, (m == 2), ((i == 7) && (la != lb)), ((i == 7) ? la : lb), 16'(exp_total));
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int   pulses;
    int   gaps;
    logic found;
    rst = 1'b1; en = 1'b0; clr = 1'b0; en4 = 1'b0; mode = 0;

    // Reset state, then re-assert reset in the middle of a probe.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {launch, terr, stall, lvl, chg, total, busy}, 32'd0);
    chk("reset_dut4", {launch4, terr4, stall4, lvl4, chg4, total4, busy4}, 32'd0);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("enter_launch", {busy, launch}, 32'b10);
    @(negedge clk);
    chk("toggle_before_sample", launch, 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_mid_sample", {launch, terr, stall, lvl, chg, total, busy}, 32'd0);

    // First probe after release: the toggle lands one cycle after leaving IDLE.
    exp_q.push_back('0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_launch_state", {busy, launch}, 32'b10);
    @(negedge clk);
    chk("first_launch_toggle", launch, 32'd1);
    wait_done(1);

    // Ideal loopback: 40 probes in total, all clean, with a 16-cycle period.
    for (int i = 0; i < 39; i++) begin
      expect_probe(0, 1'b0, 1'b0, 2'd0, 16'd0);
      chk("probe_period", 32'(tog - prev_tog), 32'd16);
    end

    // Capture tied low for four windows: the level climbs to 3, then saturates.
    run_tied0(32);
    chk("err_total_after_4_windows", total, 32'd16);

    // Reset, climb to level 2, then switch to loopback at a window boundary.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    exp_total = 0;
    run_tied0(16);
    run_window(1'b0, 2'd2, 2'd2);
    run_window(1'b0, 2'd2, 2'd2);
    run_window(1'b0, 2'd2, 2'd2);
    run_window(1'b0, 2'd2, 2'd1);
    run_window(1'b0, 2'd1, 2'd1);
    run_window(1'b0, 2'd1, 2'd1);
    run_window(1'b0, 2'd1, 2'd1);
    run_window(1'b1, 2'd1, 2'd1);  // one error: calm progress restarts
    run_window(1'b0, 2'd1, 2'd1);
    run_window(1'b0, 2'd1, 2'd1);
    run_window(1'b0, 2'd1, 2'd1);
    run_window(1'b0, 2'd1, 2'd0);
    for (int i = 0; i < 4; i++) run_window(1'b0, 2'd0, 2'd0);

    // Single forced mismatch: one-cycle error pulse, four-cycle stall.
    exp_total++;
    expect_probe(2, 1'b1, 1'b0, 2'd0, 16'(exp_total));
    mode = 0;
    @(negedge clk);
    chk("err_pulse_width", terr, 32'd0);
    chk("stall_cycle2", stall, 32'd1);
    @(negedge clk);
    chk("stall_cycle3", stall, 32'd1);
    @(negedge clk);
    chk("stall_cycle4", stall, 32'd1);
    @(negedge clk);
    chk("stall_released", stall, 32'd0);
    en = 1'b0;

    // Back-to-back mismatches every 4 cycles keep the stall request high.
    en4 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (terr4) begin
        found = 1'b1;
        break;
      end
    end
    chk("dut4_first_err", found, 32'd1);
    pulses = 0;
    gaps   = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!stall4) gaps++;
      if (terr4) pulses++;
    end
    chk("dut4_stall_continuous_gaps", 32'(gaps), 32'd0);
    chk("dut4_err_pulses", 32'(pulses), 32'd4);
    en4 = 1'b0;

    // en_i dropped during SAMPLE discards the probe, which would have failed.
    @(negedge clk);
    mode = 2;
    en = 1'b1;
    wait_toggle("abort_toggle");
    en = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_err", {terr, total}, {15'd0, 1'b0, 16'(exp_total)});
    end

    // clr_i coinciding with a failing EVAL: the error still reports, and the counters clear.
    exp_q.push_back({1'b1, 1'b0, 1'b1, 2'd0, 16'd0});
    en = 1'b1;
    wait_toggle("clr_toggle");
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_done(done_cnt < 1 ? 1 : done_cnt);
    chk("clr_err_total", total, 32'd0);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
